// File: rtl/csr_regfile.sv
// Control/status register file at the far end of the writeback CSR/exception interface.
// Holds CRMD/PRMD/ECFG/ESTAT/ERA/EENTRY/SAVE0-3/TID/TCFG/TVAL/TICLR and the constant timer.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   csr_rnum / csr_rvalue       combinational read port (ID/EX)
//   csr_we/num/wmask/wvalue     masked CSR write from WB
//   excp_flush, ertn_flush      exception / ertn commits from WB
//   wb_ecode, wb_esubcode, wb_pc  exception info of the committing instruction
//   hw_int_in, ipi_int_in       level interrupt lines
//   ex_entry, ertn_era          redirect targets (combinational)
//   has_int                     pending enabled interrupt (combinational)
module csr_regfile #(
  parameter logic [31:0] TID_RESET    = 32'h0,
  parameter logic [31:0] EENTRY_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_era,
  output logic        has_int
);

  localparam logic [13:0] AddrCrmd   = 14'h00;
  localparam logic [13:0] AddrPrmd   = 14'h01;
  localparam logic [13:0] AddrEcfg   = 14'h04;
  localparam logic [13:0] AddrEstat  = 14'h05;
  localparam logic [13:0] AddrEra    = 14'h06;
  localparam logic [13:0] AddrEentry = 14'h0C;
  localparam logic [13:0] AddrSave0  = 14'h30;
  localparam logic [13:0] AddrSave1  = 14'h31;
  localparam logic [13:0] AddrSave2  = 14'h32;
  localparam logic [13:0] AddrSave3  = 14'h33;
  localparam logic [13:0] AddrTid    = 14'h40;
  localparam logic [13:0] AddrTcfg   = 14'h41;
  localparam logic [13:0] AddrTval   = 14'h42;
  localparam logic [13:0] AddrTiclr  = 14'h44;

  // LIE[10] does not exist
  localparam logic [12:0] LieMask = 13'h1BFF;

  logic [3:0]  crmd_q, crmd_d;        // {DA, IE, PLV[1:0]}
  logic [2:0]  prmd_q, prmd_d;        // {PIE, PPLV[1:0]}
  logic [12:0] lie_q, lie_d;
  logic [12:0] is_q, is_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esubcode_q, esubcode_d;
  logic [31:0] era_q, era_d;
  logic [25:0] eentry_q, eentry_d;    // VA[31:6]
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];
  logic [31:0] tid_q, tid_d;
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        armed_q, armed_d;

  logic        wr_en;
  logic [31:0] wr_merged_tcfg;
  logic        timer_fire;
  logic        ticlr_hit;

  // Exception and ertn commits suppress a same-cycle CSR write completely.
  assign wr_en          = csr_we & ~excp_flush & ~ertn_flush;
  assign wr_merged_tcfg = (tcfg_q & ~csr_wmask) | (csr_wvalue & csr_wmask);
  assign ticlr_hit      = wr_en && (csr_num == AddrTiclr) && csr_wvalue[0] && csr_wmask[0];

  always_comb begin
    crmd_d     = crmd_q;
    prmd_d     = prmd_q;
    lie_d      = lie_q;
    is_d       = is_q;
    ecode_d    = ecode_q;
    esubcode_d = esubcode_q;
    era_d      = era_q;
    eentry_d   = eentry_q;
    save_d     = save_q;
    tid_d      = tid_q;
    tcfg_d     = tcfg_q;
    tval_d     = tval_q;
    armed_d    = armed_q;
    timer_fire = 1'b0;

    // Commit side effects
    if (excp_flush) begin
      prmd_d     = crmd_q[2:0];
      crmd_d     = {crmd_q[3], 3'b000};
      era_d      = wb_pc;
      ecode_d    = wb_ecode;
      esubcode_d = wb_esubcode;
    end else if (ertn_flush) begin
      crmd_d = {crmd_q[3], prmd_q};
    end else if (wr_en) begin
      case (csr_num)
        AddrCrmd:   crmd_d   = (crmd_q & ~csr_wmask[3:0]) | (csr_wvalue[3:0] & csr_wmask[3:0]);
        AddrPrmd:   prmd_d   = (prmd_q & ~csr_wmask[2:0]) | (csr_wvalue[2:0] & csr_wmask[2:0]);
        AddrEcfg:   lie_d    = ((lie_q & ~csr_wmask[12:0]) | (csr_wvalue[12:0] & csr_wmask[12:0]))
                               & LieMask;
        AddrEstat:  is_d[1:0] = (is_q[1:0] & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
        AddrEra:    era_d    = (era_q & ~csr_wmask) | (csr_wvalue & csr_wmask);
        AddrEentry: eentry_d = (eentry_q & ~csr_wmask[31:6]) | (csr_wvalue[31:6] & csr_wmask[31:6]);
        AddrSave0:  save_d[0] = (save_q[0] & ~csr_wmask) | (csr_wvalue & csr_wmask);
        AddrSave1:  save_d[1] = (save_q[1] & ~csr_wmask) | (csr_wvalue & csr_wmask);
        AddrSave2:  save_d[2] = (save_q[2] & ~csr_wmask) | (csr_wvalue & csr_wmask);
        AddrSave3:  save_d[3] = (save_q[3] & ~csr_wmask) | (csr_wvalue & csr_wmask);
        AddrTid:    tid_d    = (tid_q & ~csr_wmask) | (csr_wvalue & csr_wmask);
        default: ;
      endcase
    end

    // Level interrupt lines are sampled every cycle; IS[10] does not exist.
    is_d[9:2] = hw_int_in;
    is_d[12]  = ipi_int_in;
    is_d[10]  = 1'b0;

    // Timer: a TCFG write re-arms or disarms and takes precedence over counting.
    if (wr_en && (csr_num == AddrTcfg)) begin
      tcfg_d = wr_merged_tcfg;
      if (wr_merged_tcfg[0]) begin
        tval_d  = {wr_merged_tcfg[31:2], 2'b00};
        armed_d = 1'b1;
      end else begin
        armed_d = 1'b0;
      end
    end else if (tcfg_q[0] && armed_q) begin
      if (tval_q != 32'd0) begin
        tval_d = tval_q - 32'd1;
      end else begin
        timer_fire = 1'b1;
        if (tcfg_q[1]) begin
          tval_d = {tcfg_q[31:2], 2'b00};
        end else begin
          armed_d = 1'b0;
        end
      end
    end

    // TICLR beats a same-cycle timer expiry.
    if (ticlr_hit) begin
      is_d[11] = 1'b0;
    end else if (timer_fire) begin
      is_d[11] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_q     <= 4'h8;
      prmd_q     <= '0;
      lie_q      <= '0;
      is_q       <= '0;
      ecode_q    <= '0;
      esubcode_q <= '0;
      era_q      <= '0;
      eentry_q   <= EENTRY_RESET[31:6];
      for (int i = 0; i < 4; i++) save_q[i] <= '0;
      tid_q      <= TID_RESET;
      tcfg_q     <= '0;
      tval_q     <= '0;
      armed_q    <= 1'b0;
    end else begin
      crmd_q     <= crmd_d;
      prmd_q     <= prmd_d;
      lie_q      <= lie_d;
      is_q       <= is_d;
      ecode_q    <= ecode_d;
      esubcode_q <= esubcode_d;
      era_q      <= era_d;
      eentry_q   <= eentry_d;
      for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
      tid_q      <= tid_d;
      tcfg_q     <= tcfg_d;
      tval_q     <= tval_d;
      armed_q    <= armed_d;
    end
  end

  // Read port: no bypass of the in-flight write.
  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_rnum)
      AddrCrmd:   csr_rvalue = {28'h0, crmd_q};
      AddrPrmd:   csr_rvalue = {29'h0, prmd_q};
      AddrEcfg:   csr_rvalue = {19'h0, lie_q};
      AddrEstat:  csr_rvalue = {1'b0, esubcode_q, ecode_q, 3'b000, is_q};
      AddrEra:    csr_rvalue = era_q;
      AddrEentry: csr_rvalue = {eentry_q, 6'h0};
      AddrSave0:  csr_rvalue = save_q[0];
      AddrSave1:  csr_rvalue = save_q[1];
      AddrSave2:  csr_rvalue = save_q[2];
      AddrSave3:  csr_rvalue = save_q[3];
      AddrTid:    csr_rvalue = tid_q;
      AddrTcfg:   csr_rvalue = tcfg_q;
      AddrTval:   csr_rvalue = tval_q;
      default:    csr_rvalue = 32'h0;
    endcase
  end

  assign ex_entry = {eentry_q, 6'h0};
  assign ertn_era = era_q;
  assign has_int  = crmd_q[2] & (|(is_q & lie_q));

endmodule

// File: tb/tb_csr_regfile.sv
module tb_csr_regfile;

  localparam logic [31:0] TidRst    = 32'h0000_0A5A;
  localparam logic [31:0] EentryRst = 32'h1C00_0000;

  logic        clk;
  logic        reset;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        excp_flush;
  logic        ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_era;
  logic        has_int;

  csr_regfile #(
    .TID_RESET   (TidRst),
    .EENTRY_RESET(EentryRst)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .csr_rnum   (csr_rnum),
    .csr_rvalue (csr_rvalue),
    .csr_we     (csr_we),
    .csr_num    (csr_num),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .excp_flush (excp_flush),
    .ertn_flush (ertn_flush),
    .wb_ecode   (wb_ecode),
    .wb_esubcode(wb_esubcode),
    .wb_pc      (wb_pc),
    .hw_int_in  (hw_int_in),
    .ipi_int_in (ipi_int_in),
    .ex_entry   (ex_entry),
    .ertn_era   (ertn_era),
    .has_int    (has_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural state as whole 32-bit words, as software sees them.
  typedef struct packed {
    logic [31:0]       crmd;
    logic [31:0]       prmd;
    logic [31:0]       ecfg;
    logic [31:0]       estat;
    logic [31:0]       era;
    logic [31:0]       eentry;
    logic [3:0][31:0]  save;
    logic [31:0]       tid;
    logic [31:0]       tcfg;
    logic [31:0]       tval;
    logic              armed;
  } model_t;

  model_t m;

  function automatic logic [31:0] writable(input logic [13:0] a);
    case (a)
      14'h00: return 32'h0000_000F;
      14'h01: return 32'h0000_0007;
      14'h04: return 32'h0000_1BFF;
      14'h05: return 32'h0000_0003;
      14'h06, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41: return 32'hFFFF_FFFF;
      14'h0C: return 32'hFFFF_FFC0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] v,
                                        input logic [31:0] k);
    return (o & ~k) | (v & k);
  endfunction

  function automatic model_t model_reset();
    model_t r = '0;
    r.crmd   = 32'h8;
    r.tid    = TidRst;
    r.eentry = EentryRst & 32'hFFFF_FFC0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t s);
    model_t n = s;
    logic wr;
    logic [31:0] k;
    logic [31:0] cfg;
    if (reset) return model_reset();
    n.estat[9:2] = hw_int_in;
    n.estat[12]  = ipi_int_in;
    wr = csr_we && !excp_flush && !ertn_flush;
    if (excp_flush) begin
      n.prmd         = {29'h0, s.crmd[2:0]};
      n.crmd[2:0]    = 3'b000;
      n.era          = wb_pc;
      n.estat[21:16] = wb_ecode;
      n.estat[30:22] = wb_esubcode;
    end else if (ertn_flush) begin
      n.crmd[2:0] = s.prmd[2:0];
    end
    cfg = merge(s.tcfg, csr_wvalue, csr_wmask);
    if (wr && csr_num == 14'h41) begin
      n.tcfg = cfg;
      if (cfg[0]) begin
        n.tval  = cfg & 32'hFFFF_FFFC;
        n.armed = 1'b1;
      end else begin
        n.armed = 1'b0;
      end
    end else if (s.tcfg[0] && s.armed) begin
      if (s.tval != 0) n.tval = s.tval - 1;
      else begin
        n.estat[11] = 1'b1;
        if (s.tcfg[1]) n.tval = s.tcfg & 32'hFFFF_FFFC;
        else n.armed = 1'b0;
      end
    end
    if (wr) begin
      k = csr_wmask & writable(csr_num);
      case (csr_num)
        14'h00: n.crmd   = merge(s.crmd, csr_wvalue, k);
        14'h01: n.prmd   = merge(s.prmd, csr_wvalue, k);
        14'h04: n.ecfg   = merge(s.ecfg, csr_wvalue, k);
        14'h05: n.estat  = merge(n.estat, csr_wvalue, k);
        14'h06: n.era    = merge(s.era, csr_wvalue, k);
        14'h0C: n.eentry = merge(s.eentry, csr_wvalue, k);
        14'h30, 14'h31, 14'h32, 14'h33:
          n.save[csr_num[1:0]] = merge(s.save[csr_num[1:0]], csr_wvalue, k);
        14'h40: n.tid    = merge(s.tid, csr_wvalue, k);
        14'h44: if (csr_wvalue[0] && csr_wmask[0]) n.estat[11] = 1'b0;
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] model_read(input model_t s, input logic [13:0] a);
    case (a)
      14'h00: return s.crmd;
      14'h01: return s.prmd;
      14'h04: return s.ecfg;
      14'h05: return s.estat;
      14'h06: return s.era;
      14'h0C: return s.eentry;
      14'h30, 14'h31, 14'h32, 14'h33: return s.save[a[1:0]];
      14'h40: return s.tid;
      14'h41: return s.tcfg;
      14'h42: return s.tval;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) m <= model_next(m);

  always @(negedge clk) begin
    if (chk_en) begin
      check("rvalue", csr_rvalue, model_read(m, csr_rnum));
      check("ex_entry", ex_entry, m.eentry);
      check("ertn_era", ertn_era, m.era);
      check("has_int", {31'h0, has_int},
            {31'h0, m.crmd[2] & (|(m.estat[12:0] & m.ecfg[12:0]))});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [13:0] a, input logic [31:0] v, input logic [31:0] k);
    csr_we = 1'b1; csr_num = a; csr_wvalue = v; csr_wmask = k;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [13:0] a, input logic [31:0] exp);
    csr_rnum = a;
    #1;
    check(name, csr_rvalue, exp);
  endtask

  function automatic logic [13:0] pick_addr(input int unsigned r);
    case (r % 17)
      0: return 14'h00;  1: return 14'h01;  2: return 14'h04;  3: return 14'h05;
      4: return 14'h06;  5: return 14'h0C;  6: return 14'h30;  7: return 14'h31;
      8: return 14'h32;  9: return 14'h33;  10: return 14'h40; 11: return 14'h41;
      12: return 14'h42; 13: return 14'h44; 14: return 14'h07;
      default: return 14'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; csr_rnum = '0; csr_we = 1'b0; csr_num = '0; csr_wmask = '0;
    csr_wvalue = '0; excp_flush = 1'b0; ertn_flush = 1'b0; wb_ecode = '0;
    wb_esubcode = '0; wb_pc = '0; hw_int_in = '0; ipi_int_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    rd("rst_crmd", 14'h00, 32'h8);
    rd("rst_tid", 14'h40, TidRst);
    check("rst_ex_entry", ex_entry, 32'h1C00_0000);
    check("rst_era", ertn_era, 32'h0);
    check("rst_has_int", {31'h0, has_int}, 32'h0);

    // EENTRY low bits read as zero
    do_write(14'h0C, 32'h1C00_8044, 32'hFFFF_FFFF);
    rd("eentry", 14'h0C, 32'h1C00_8040);
    check("ex_entry", ex_entry, 32'h1C00_8040);

    // Exception commit
    do_write(14'h00, 32'h7, 32'hFFFF_FFFF);
    excp_flush = 1'b1; wb_ecode = 6'hB; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100;
    tick();
    excp_flush = 1'b0;
    rd("excp_prmd", 14'h01, 32'h7);
    rd("excp_crmd", 14'h00, 32'h0);
    rd("excp_era", 14'h06, 32'h1C00_0100);
    check("excp_ecode", {26'h0, csr_rvalue[5:0]}, 32'h0);
    rd("excp_estat", 14'h05, 32'h000B_0000);

    // Ertn restores PLV/IE
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    rd("ertn_crmd", 14'h00, 32'h7);

    // Exception beats ertn and write in the same cycle
    do_write(14'h30, 32'h1234_5678, 32'hFFFF_FFFF);
    excp_flush = 1'b1; ertn_flush = 1'b1; wb_ecode = 6'h3; wb_pc = 32'h1C00_0200;
    do_write(14'h30, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    excp_flush = 1'b0; ertn_flush = 1'b0;
    rd("prio_save0", 14'h30, 32'h1234_5678);
    rd("prio_era", 14'h06, 32'h1C00_0200);
    rd("prio_crmd", 14'h00, 32'h0);

    // Periodic timer, InitVal=2
    do_write(14'h41, 32'h0000_000B, 32'hFFFF_FFFF);
    rd("tval_load", 14'h42, 32'd8);
    for (int i = 7; i >= 0; i--) begin
      tick();
      rd("tval_count", 14'h42, 32'(i));
    end
    rd("is11_pre", 14'h05, 32'h0003_0000);
    tick();
    rd("is11_set", 14'h05, 32'h0003_0800);
    rd("tval_reload", 14'h42, 32'd8);
    do_write(14'h44, 32'h1, 32'h1);
    rd("ticlr_clear", 14'h05, 32'h0003_0000);
    rd("ticlr_read", 14'h44, 32'h0);
    do_write(14'h41, 32'h0, 32'hFFFF_FFFF);
    tick();
    rd("tval_hold", 14'h42, 32'd7);

    // Hardware interrupt path
    do_write(14'h04, 32'h4, 32'hFFFF_FFFF);
    do_write(14'h00, 32'h4, 32'h4);
    hw_int_in = 8'h01;
    #1;
    check("int_pre", {31'h0, has_int}, 32'h0);
    tick();
    check("int_set", {31'h0, has_int}, 32'h1);
    hw_int_in = 8'h00;
    do_write(14'h00, 32'h0, 32'h4);
    check("int_ie0", {31'h0, has_int}, 32'h0);

    // ESTAT write protection and unlisted address
    do_write(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("estat_prot", 14'h05, 32'h0003_0003);
    do_write(14'h07, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("unlisted", 14'h07, 32'h0);
    do_write(14'h05, 32'h0, 32'h3);

    // Reset during countdown
    do_write(14'h41, 32'h0000_000B, 32'hFFFF_FFFF);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("mid_rst_crmd", 14'h00, 32'h8);
    rd("mid_rst_tval", 14'h42, 32'h0);
    check("mid_rst_int", {31'h0, has_int}, 32'h0);
    tick(); tick(); tick();
    rd("mid_rst_idle", 14'h42, 32'h0);

    // Randomized phase against the model
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(0, 499) == 0);
      excp_flush  = ($urandom_range(0, 29) == 0);
      ertn_flush  = ($urandom_range(0, 29) == 0);
      wb_ecode    = 6'($urandom);
      wb_esubcode = 9'($urandom);
      wb_pc       = $urandom;
      csr_we      = ($urandom_range(0, 2) == 0);
      csr_num     = pick_addr($urandom);
      csr_wvalue  = $urandom;
      csr_wmask   = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
      if (csr_num == 14'h41) begin
        csr_wvalue = $urandom & 32'h1F;
        csr_wmask  = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 9) == 0) hw_int_in = 8'($urandom);
      if ($urandom_range(0, 9) == 0) ipi_int_in = 1'($urandom);
      csr_rnum = pick_addr($urandom);
      tick();
    end

    reset = 1'b0; csr_we = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
